// File: rtl/aes_pkg.sv
// Shared AES byte-substitution definitions: FSM states and the FIPS-197 forward/inverse S-box tables.
package aes_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  function automatic logic [7:0] sbox_fwd(input logic [7:0] x);
    logic [7:0] s;
    s = 8'h00;
    case (x)
      8'h00: s = 8'h63; 8'h01: s = 8'h7c; 8'h02: s = 8'h77; 8'h03: s = 8'h7b; 8'h04: s = 8'hf2; 8'h05: s = 8'h6b; 8'h06: s = 8'h6f; 8'h07: s = 8'hc5;
      8'h08: s = 8'h30; 8'h09: s = 8'h01; 8'h0a: s = 8'h67; 8'h0b: s = 8'h2b; 8'h0c: s = 8'hfe; 8'h0d: s = 8'hd7; 8'h0e: s = 8'hab; 8'h0f: s = 8'h76;
      8'h10: s = 8'hca; 8'h11: s = 8'h82; 8'h12: s = 8'hc9; 8'h13: s = 8'h7d; 8'h14: s = 8'hfa; 8'h15: s = 8'h59; 8'h16: s = 8'h47; 8'h17: s = 8'hf0;
      8'h18: s = 8'had; 8'h19: s = 8'hd4; 8'h1a: s = 8'ha2; 8'h1b: s = 8'haf; 8'h1c: s = 8'h9c; 8'h1d: s = 8'ha4; 8'h1e: s = 8'h72; 8'h1f: s = 8'hc0;
      8'h20: s = 8'hb7; 8'h21: s = 8'hfd; 8'h22: s = 8'h93; 8'h23: s = 8'h26; 8'h24: s = 8'h36; 8'h25: s = 8'h3f; 8'h26: s = 8'hf7; 8'h27: s = 8'hcc;
      8'h28: s = 8'h34; 8'h29: s = 8'ha5; 8'h2a: s = 8'he5; 8'h2b: s = 8'hf1; 8'h2c: s = 8'h71; 8'h2d: s = 8'hd8; 8'h2e: s = 8'h31; 8'h2f: s = 8'h15;
      8'h30: s = 8'h04; 8'h31: s = 8'hc7; 8'h32: s = 8'h23; 8'h33: s = 8'hc3; 8'h34: s = 8'h18; 8'h35: s = 8'h96; 8'h36: s = 8'h05; 8'h37: s = 8'h9a;
      8'h38: s = 8'h07; 8'h39: s = 8'h12; 8'h3a: s = 8'h80; 8'h3b: s = 8'he2; 8'h3c: s = 8'heb; 8'h3d: s = 8'h27; 8'h3e: s = 8'hb2; 8'h3f: s = 8'h75;
      8'h40: s = 8'h09; 8'h41: s = 8'h83; 8'h42: s = 8'h2c; 8'h43: s = 8'h1a; 8'h44: s = 8'h1b; 8'h45: s = 8'h6e; 8'h46: s = 8'h5a; 8'h47: s = 8'ha0;
      8'h48: s = 8'h52; 8'h49: s = 8'h3b; 8'h4a: s = 8'hd6; 8'h4b: s = 8'hb3; 8'h4c: s = 8'h29; 8'h4d: s = 8'he3; 8'h4e: s = 8'h2f; 8'h4f: s = 8'h84;
      8'h50: s = 8'h53; 8'h51: s = 8'hd1; 8'h52: s = 8'h00; 8'h53: s = 8'hed; 8'h54: s = 8'h20; 8'h55: s = 8'hfc; 8'h56: s = 8'hb1; 8'h57: s = 8'h5b;
      8'h58: s = 8'h6a; 8'h59: s = 8'hcb; 8'h5a: s = 8'hbe; 8'h5b: s = 8'h39; 8'h5c: s = 8'h4a; 8'h5d: s = 8'h4c; 8'h5e: s = 8'h58; 8'h5f: s = 8'hcf;
      8'h60: s = 8'hd0; 8'h61: s = 8'hef; 8'h62: s = 8'haa; 8'h63: s = 8'hfb; 8'h64: s = 8'h43; 8'h65: s = 8'h4d; 8'h66: s = 8'h33; 8'h67: s = 8'h85;
      8'h68: s = 8'h45; 8'h69: s = 8'hf9; 8'h6a: s = 8'h02; 8'h6b: s = 8'h7f; 8'h6c: s = 8'h50; 8'h6d: s = 8'h3c; 8'h6e: s = 8'h9f; 8'h6f: s = 8'ha8;
      8'h70: s = 8'h51; 8'h71: s = 8'ha3; 8'h72: s = 8'h40; 8'h73: s = 8'h8f; 8'h74: s = 8'h92; 8'h75: s = 8'h9d; 8'h76: s = 8'h38; 8'h77: s = 8'hf5;
      8'h78: s = 8'hbc; 8'h79: s = 8'hb6; 8'h7a: s = 8'hda; 8'h7b: s = 8'h21; 8'h7c: s = 8'h10; 8'h7d: s = 8'hff; 8'h7e: s = 8'hf3; 8'h7f: s = 8'hd2;
      8'h80: s = 8'hcd; 8'h81: s = 8'h0c; 8'h82: s = 8'h13; 8'h83: s = 8'hec; 8'h84: s = 8'h5f; 8'h85: s = 8'h97; 8'h86: s = 8'h44; 8'h87: s = 8'h17;
      8'h88: s = 8'hc4; 8'h89: s = 8'ha7; 8'h8a: s = 8'h7e; 8'h8b: s = 8'h3d; 8'h8c: s = 8'h64; 8'h8d: s = 8'h5d; 8'h8e: s = 8'h19; 8'h8f: s = 8'h73;
      8'h90: s = 8'h60; 8'h91: s = 8'h81; 8'h92: s = 8'h4f; 8'h93: s = 8'hdc; 8'h94: s = 8'h22; 8'h95: s = 8'h2a; 8'h96: s = 8'h90; 8'h97: s = 8'h88;
      8'h98: s = 8'h46; 8'h99: s = 8'hee; 8'h9a: s = 8'hb8; 8'h9b: s = 8'h14; 8'h9c: s = 8'hde; 8'h9d: s = 8'h5e; 8'h9e: s = 8'h0b; 8'h9f: s = 8'hdb;
      8'ha0: s = 8'he0; 8'ha1: s = 8'h32; 8'ha2: s = 8'h3a; 8'ha3: s = 8'h0a; 8'ha4: s = 8'h49; 8'ha5: s = 8'h06; 8'ha6: s = 8'h24; 8'ha7: s = 8'h5c;
      8'ha8: s = 8'hc2; 8'ha9: s = 8'hd3; 8'haa: s = 8'hac; 8'hab: s = 8'h62; 8'hac: s = 8'h91; 8'had: s = 8'h95; 8'hae: s = 8'he4; 8'haf: s = 8'h79;
      8'hb0: s = 8'he7; 8'hb1: s = 8'hc8; 8'hb2: s = 8'h37; 8'hb3: s = 8'h6d; 8'hb4: s = 8'h8d; 8'hb5: s = 8'hd5; 8'hb6: s = 8'h4e; 8'hb7: s = 8'ha9;
      8'hb8: s = 8'h6c; 8'hb9: s = 8'h56; 8'hba: s = 8'hf4; 8'hbb: s = 8'hea; 8'hbc: s = 8'h65; 8'hbd: s = 8'h7a; 8'hbe: s = 8'hae; 8'hbf: s = 8'h08;
      8'hc0: s = 8'hba; 8'hc1: s = 8'h78; 8'hc2: s = 8'h25; 8'hc3: s = 8'h2e; 8'hc4: s = 8'h1c; 8'hc5: s = 8'ha6; 8'hc6: s = 8'hb4; 8'hc7: s = 8'hc6;
      8'hc8: s = 8'he8; 8'hc9: s = 8'hdd; 8'hca: s = 8'h74; 8'hcb: s = 8'h1f; 8'hcc: s = 8'h4b; 8'hcd: s = 8'hbd; 8'hce: s = 8'h8b; 8'hcf: s = 8'h8a;
      8'hd0: s = 8'h70; 8'hd1: s = 8'h3e; 8'hd2: s = 8'hb5; 8'hd3: s = 8'h66; 8'hd4: s = 8'h48; 8'hd5: s = 8'h03; 8'hd6: s = 8'hf6; 8'hd7: s = 8'h0e;
      8'hd8: s = 8'h61; 8'hd9: s = 8'h35; 8'hda: s = 8'h57; 8'hdb: s = 8'hb9; 8'hdc: s = 8'h86; 8'hdd: s = 8'hc1; 8'hde: s = 8'h1d; 8'hdf: s = 8'h9e;
      8'he0: s = 8'he1; 8'he1: s = 8'hf8; 8'he2: s = 8'h98; 8'he3: s = 8'h11; 8'he4: s = 8'h69; 8'he5: s = 8'hd9; 8'he6: s = 8'h8e; 8'he7: s = 8'h94;
      8'he8: s = 8'h9b; 8'he9: s = 8'h1e; 8'hea: s = 8'h87; 8'heb: s = 8'he9; 8'hec: s = 8'hce; 8'hed: s = 8'h55; 8'hee: s = 8'h28; 8'hef: s = 8'hdf;
      8'hf0: s = 8'h8c; 8'hf1: s = 8'ha1; 8'hf2: s = 8'h89; 8'hf3: s = 8'h0d; 8'hf4: s = 8'hbf; 8'hf5: s = 8'he6; 8'hf6: s = 8'h42; 8'hf7: s = 8'h68;
      8'hf8: s = 8'h41; 8'hf9: s = 8'h99; 8'hfa: s = 8'h2d; 8'hfb: s = 8'h0f; 8'hfc: s = 8'hb0; 8'hfd: s = 8'h54; 8'hfe: s = 8'hbb; 8'hff: s = 8'h16;
    endcase
    return s;
  endfunction

  function automatic logic [7:0] sbox_inv(input logic [7:0] x);
    logic [7:0] s;
    s = 8'h00;
    case (x)
      8'h00: s = 8'h52; 8'h01: s = 8'h09; 8'h02: s = 8'h6a; 8'h03: s = 8'hd5; 8'h04: s = 8'h30; 8'h05: s = 8'h36; 8'h06: s = 8'ha5; 8'h07: s = 8'h38;
      8'h08: s = 8'hbf; 8'h09: s = 8'h40; 8'h0a: s = 8'ha3; 8'h0b: s = 8'h9e; 8'h0c: s = 8'h81; 8'h0d: s = 8'hf3; 8'h0e: s = 8'hd7; 8'h0f: s = 8'hfb;
      8'h10: s = 8'h7c; 8'h11: s = 8'he3; 8'h12: s = 8'h39; 8'h13: s = 8'h82; 8'h14: s = 8'h9b; 8'h15: s = 8'h2f; 8'h16: s = 8'hff; 8'h17: s = 8'h87;
      8'h18: s = 8'h34; 8'h19: s = 8'h8e; 8'h1a: s = 8'h43; 8'h1b: s = 8'h44; 8'h1c: s = 8'hc4; 8'h1d: s = 8'hde; 8'h1e: s = 8'he9; 8'h1f: s = 8'hcb;
      8'h20: s = 8'h54; 8'h21: s = 8'h7b; 8'h22: s = 8'h94; 8'h23: s = 8'h32; 8'h24: s = 8'ha6; 8'h25: s = 8'hc2; 8'h26: s = 8'h23; 8'h27: s = 8'h3d;
      8'h28: s = 8'hee; 8'h29: s = 8'h4c; 8'h2a: s = 8'h95; 8'h2b: s = 8'h0b; 8'h2c: s = 8'h42; 8'h2d: s = 8'hfa; 8'h2e: s = 8'hc3; 8'h2f: s = 8'h4e;
      8'h30: s = 8'h08; 8'h31: s = 8'h2e; 8'h32: s = 8'ha1; 8'h33: s = 8'h66; 8'h34: s = 8'h28; 8'h35: s = 8'hd9; 8'h36: s = 8'h24; 8'h37: s = 8'hb2;
      8'h38: s = 8'h76; 8'h39: s = 8'h5b; 8'h3a: s = 8'ha2; 8'h3b: s = 8'h49; 8'h3c: s = 8'h6d; 8'h3d: s = 8'h8b; 8'h3e: s = 8'hd1; 8'h3f: s = 8'h25;
      8'h40: s = 8'h72; 8'h41: s = 8'hf8; 8'h42: s = 8'hf6; 8'h43: s = 8'h64; 8'h44: s = 8'h86; 8'h45: s = 8'h68; 8'h46: s = 8'h98; 8'h47: s = 8'h16;
      8'h48: s = 8'hd4; 8'h49: s = 8'ha4; 8'h4a: s = 8'h5c; 8'h4b: s = 8'hcc; 8'h4c: s = 8'h5d; 8'h4d: s = 8'h65; 8'h4e: s = 8'hb6; 8'h4f: s = 8'h92;
      8'h50: s = 8'h6c; 8'h51: s = 8'h70; 8'h52: s = 8'h48; 8'h53: s = 8'h50; 8'h54: s = 8'hfd; 8'h55: s = 8'hed; 8'h56: s = 8'hb9; 8'h57: s = 8'hda;
      8'h58: s = 8'h5e; 8'h59: s = 8'h15; 8'h5a: s = 8'h46; 8'h5b: s = 8'h57; 8'h5c: s = 8'ha7; 8'h5d: s = 8'h8d; 8'h5e: s = 8'h9d; 8'h5f: s = 8'h84;
      8'h60: s = 8'h90; 8'h61: s = 8'hd8; 8'h62: s = 8'hab; 8'h63: s = 8'h00; 8'h64: s = 8'h8c; 8'h65: s = 8'hbc; 8'h66: s = 8'hd3; 8'h67: s = 8'h0a;
      8'h68: s = 8'hf7; 8'h69: s = 8'he4; 8'h6a: s = 8'h58; 8'h6b: s = 8'h05; 8'h6c: s = 8'hb8; 8'h6d: s = 8'hb3; 8'h6e: s = 8'h45; 8'h6f: s = 8'h06;
      8'h70: s = 8'hd0; 8'h71: s = 8'h2c; 8'h72: s = 8'h1e; 8'h73: s = 8'h8f; 8'h74: s = 8'hca; 8'h75: s = 8'h3f; 8'h76: s = 8'h0f; 8'h77: s = 8'h02;
      8'h78: s = 8'hc1; 8'h79: s = 8'haf; 8'h7a: s = 8'hbd; 8'h7b: s = 8'h03; 8'h7c: s = 8'h01; 8'h7d: s = 8'h13; 8'h7e: s = 8'h8a; 8'h7f: s = 8'h6b;
      8'h80: s = 8'h3a; 8'h81: s = 8'h91; 8'h82: s = 8'h11; 8'h83: s = 8'h41; 8'h84: s = 8'h4f; 8'h85: s = 8'h67; 8'h86: s = 8'hdc; 8'h87: s = 8'hea;
      8'h88: s = 8'h97; 8'h89: s = 8'hf2; 8'h8a: s = 8'hcf; 8'h8b: s = 8'hce; 8'h8c: s = 8'hf0; 8'h8d: s = 8'hb4; 8'h8e: s = 8'he6; 8'h8f: s = 8'h73;
      8'h90: s = 8'h96; 8'h91: s = 8'hac; 8'h92: s = 8'h74; 8'h93: s = 8'h22; 8'h94: s = 8'he7; 8'h95: s = 8'had; 8'h96: s = 8'h35; 8'h97: s = 8'h85;
      8'h98: s = 8'he2; 8'h99: s = 8'hf9; 8'h9a: s = 8'h37; 8'h9b: s = 8'he8; 8'h9c: s = 8'h1c; 8'h9d: s = 8'h75; 8'h9e: s = 8'hdf; 8'h9f: s = 8'h6e;
      8'ha0: s = 8'h47; 8'ha1: s = 8'hf1; 8'ha2: s = 8'h1a; 8'ha3: s = 8'h71; 8'ha4: s = 8'h1d; 8'ha5: s = 8'h29; 8'ha6: s = 8'hc5; 8'ha7: s = 8'h89;
      8'ha8: s = 8'h6f; 8'ha9: s = 8'hb7; 8'haa: s = 8'h62; 8'hab: s = 8'h0e; 8'hac: s = 8'haa; 8'had: s = 8'h18; 8'hae: s = 8'hbe; 8'haf: s = 8'h1b;
      8'hb0: s = 8'hfc; 8'hb1: s = 8'h56; 8'hb2: s = 8'h3e; 8'hb3: s = 8'h4b; 8'hb4: s = 8'hc6; 8'hb5: s = 8'hd2; 8'hb6: s = 8'h79; 8'hb7: s = 8'h20;
      8'hb8: s = 8'h9a; 8'hb9: s = 8'hdb; 8'hba: s = 8'hc0; 8'hbb: s = 8'hfe; 8'hbc: s = 8'h78; 8'hbd: s = 8'hcd; 8'hbe: s = 8'h5a; 8'hbf: s = 8'hf4;
      8'hc0: s = 8'h1f; 8'hc1: s = 8'hdd; 8'hc2: s = 8'ha8; 8'hc3: s = 8'h33; 8'hc4: s = 8'h88; 8'hc5: s = 8'h07; 8'hc6: s = 8'hc7; 8'hc7: s = 8'h31;
      8'hc8: s = 8'hb1; 8'hc9: s = 8'h12; 8'hca: s = 8'h10; 8'hcb: s = 8'h59; 8'hcc: s = 8'h27; 8'hcd: s = 8'h80; 8'hce: s = 8'hec; 8'hcf: s = 8'h5f;
      8'hd0: s = 8'h60; 8'hd1: s = 8'h51; 8'hd2: s = 8'h7f; 8'hd3: s = 8'ha9; 8'hd4: s = 8'h19; 8'hd5: s = 8'hb5; 8'hd6: s = 8'h4a; 8'hd7: s = 8'h0d;
      8'hd8: s = 8'h2d; 8'hd9: s = 8'he5; 8'hda: s = 8'h7a; 8'hdb: s = 8'h9f; 8'hdc: s = 8'h93; 8'hdd: s = 8'hc9; 8'hde: s = 8'h9c; 8'hdf: s = 8'hef;
      8'he0: s = 8'ha0; 8'he1: s = 8'he0; 8'he2: s = 8'h3b; 8'he3: s = 8'h4d; 8'he4: s = 8'hae; 8'he5: s = 8'h2a; 8'he6: s = 8'hf5; 8'he7: s = 8'hb0;
      8'he8: s = 8'hc8; 8'he9: s = 8'heb; 8'hea: s = 8'hbb; 8'heb: s = 8'h3c; 8'hec: s = 8'h83; 8'hed: s = 8'h53; 8'hee: s = 8'h99; 8'hef: s = 8'h61;
      8'hf0: s = 8'h17; 8'hf1: s = 8'h2b; 8'hf2: s = 8'h04; 8'hf3: s = 8'h7e; 8'hf4: s = 8'hba; 8'hf5: s = 8'h77; 8'hf6: s = 8'hd6; 8'hf7: s = 8'h26;
      8'hf8: s = 8'he1; 8'hf9: s = 8'h69; 8'hfa: s = 8'h14; 8'hfb: s = 8'h63; 8'hfc: s = 8'h55; 8'hfd: s = 8'h21; 8'hfe: s = 8'h0c; 8'hff: s = 8'h7d;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/sub_bytes_engine_if.sv
// Word handshake between the AddRoundKey stage, the SubBytes engine and ShiftRows.
interface sub_bytes_engine_if #(
  parameter int NBYTES = 16
);
  logic                in_valid;
  logic                in_ready;
  logic                in_inv;
  logic [8*NBYTES-1:0] in_data;
  logic                out_valid;
  logic                out_ready;
  logic [8*NBYTES-1:0] out_data;
  logic                busy;

  modport master (
    output in_valid, in_inv, in_data, out_ready,
    input  in_ready, out_valid, out_data, busy
  );

  modport slave (
    input  in_valid, in_inv, in_data, out_ready,
    output in_ready, out_valid, out_data, busy
  );
endinterface

// File: rtl/aes_sbox_lane.sv
// One S-box lane: byte in, forward or inverse substitution out.
// Latency: combinational.
// Backpressure: none; the enclosing engine sequences the lanes.
module aes_sbox_lane
  import aes_pkg::*;
#(
  parameter int INV_EN = 1
) (
  input  logic [BYTE_W-1:0] in_byte,
  input  logic              inv,
  output logic [BYTE_W-1:0] out_byte
);

  if (INV_EN != 0) begin : g_inv
    assign out_byte = inv ? sbox_inv(in_byte) : sbox_fwd(in_byte);
  end else begin : g_fwd
    // Forward-only build: the inverse table is never elaborated.
    logic unused_inv;
    assign unused_inv = inv;
    assign out_byte   = sbox_fwd(in_byte);
  end

endmodule

// File: rtl/sub_bytes_engine.sv
// AES SubBytes/InvSubBytes over one state word, LANES bytes per beat.
// Latency: out_valid rises NBYTES/LANES edges after accept; one word per NBYTES/LANES+2 cycles.
// Backpressure: result held in DONE until out_ready; in_ready is high only in IDLE.
module sub_bytes_engine
  import aes_pkg::*;
#(
  parameter int NBYTES = 16,
  parameter int LANES  = 4,
  parameter int INV_EN = 1
) (
  input logic               clk,
  input logic               rst,
  sub_bytes_engine_if.slave bus
);

  localparam int B  = NBYTES / LANES;
  localparam int BW = (B > 1) ? $clog2(B) : 1;

  if (LANES < 1 || (NBYTES % LANES) != 0) begin : g_lanes_check
    $error("sub_bytes_engine: LANES (%0d) must divide NBYTES (%0d)", LANES, NBYTES);
  end

  state_e                   state;
  logic [BW-1:0]            beat;
  logic [BYTE_W*NBYTES-1:0] data_q;
  logic                     mode_q;
  logic                     in_ready_q;
  logic                     out_valid_q;
  logic                     busy_q;

  logic [BYTE_W-1:0] lane_in  [LANES];
  logic [BYTE_W-1:0] lane_out [LANES];

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    assign lane_in[k] = data_q[(int'(beat) * LANES + k) * BYTE_W +: BYTE_W];

    aes_sbox_lane #(
      .INV_EN (INV_EN)
    ) u_lane (
      .in_byte  (lane_in[k]),
      .inv      (mode_q),
      .out_byte (lane_out[k])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      beat        <= '0;
      data_q      <= '0;
      mode_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid && in_ready_q) begin
            data_q     <= bus.in_data;
            mode_q     <= bus.in_inv && (INV_EN != 0);
            beat       <= '0;
            state      <= BUSY;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
        BUSY: begin
          // Substitute the current beat's bytes in place; everything else holds.
          for (int k = 0; k < LANES; k++) begin
            data_q[(int'(beat) * LANES + k) * BYTE_W +: BYTE_W] <= lane_out[k];
          end
          if (beat == BW'(B - 1)) begin
            beat        <= '0;
            state       <= DONE;
            out_valid_q <= 1'b1;
          end else begin
            beat <= beat + 1'b1;
          end
        end
        DONE: begin
          // Returning to IDLE takes this edge; the next accept is one cycle later.
          if (bus.out_ready) begin
            state       <= IDLE;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state       <= IDLE;
          beat        <= '0;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = data_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_sub_bytes_engine.sv
// Directed bench for sub_bytes_engine: default build plus LANES=16, LANES=1 and forward-only variants.
module tb_sub_bytes_engine;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic         drv_valid = 1'b0;
  logic         drv_inv   = 1'b0;
  logic         drv_ready = 1'b0;
  logic [127:0] drv_data  = '0;
  int           sel       = 0;

  sub_bytes_engine_if #(.NBYTES(16)) bus0 ();
  sub_bytes_engine_if #(.NBYTES(16)) bus1 ();
  sub_bytes_engine_if #(.NBYTES(16)) bus2 ();
  sub_bytes_engine_if #(.NBYTES(16)) bus3 ();

  assign bus0.in_valid  = drv_valid && (sel == 0);
  assign bus1.in_valid  = drv_valid && (sel == 1);
  assign bus2.in_valid  = drv_valid && (sel == 2);
  assign bus3.in_valid  = drv_valid && (sel == 3);
  assign bus0.out_ready = drv_ready && (sel == 0);
  assign bus1.out_ready = drv_ready && (sel == 1);
  assign bus2.out_ready = drv_ready && (sel == 2);
  assign bus3.out_ready = drv_ready && (sel == 3);
  assign bus0.in_inv = drv_inv;  assign bus0.in_data = drv_data;
  assign bus1.in_inv = drv_inv;  assign bus1.in_data = drv_data;
  assign bus2.in_inv = drv_inv;  assign bus2.in_data = drv_data;
  assign bus3.in_inv = drv_inv;  assign bus3.in_data = drv_data;

  sub_bytes_engine #(.NBYTES(16), .LANES(4),  .INV_EN(1)) u_dut   (.clk(clk), .rst(rst), .bus(bus0));
  sub_bytes_engine #(.NBYTES(16), .LANES(16), .INV_EN(1)) u_l16   (.clk(clk), .rst(rst), .bus(bus1));
  sub_bytes_engine #(.NBYTES(16), .LANES(1),  .INV_EN(1)) u_l1    (.clk(clk), .rst(rst), .bus(bus2));
  sub_bytes_engine #(.NBYTES(16), .LANES(4),  .INV_EN(0)) u_noinv (.clk(clk), .rst(rst), .bus(bus3));

  logic         o_valid, o_in_ready, o_busy;
  logic [127:0] o_data;

  always_comb begin
    o_valid = bus0.out_valid; o_in_ready = bus0.in_ready; o_busy = bus0.busy; o_data = bus0.out_data;
    case (sel)
      1: begin o_valid = bus1.out_valid; o_in_ready = bus1.in_ready; o_busy = bus1.busy; o_data = bus1.out_data; end
      2: begin o_valid = bus2.out_valid; o_in_ready = bus2.in_ready; o_busy = bus2.busy; o_data = bus2.out_data; end
      3: begin o_valid = bus3.out_valid; o_in_ready = bus3.in_ready; o_busy = bus3.busy; o_data = bus3.out_data; end
      default: ;
    endcase
  end

  // Vectors written byte 0 first; bswap places byte 0 in bits [7:0].
  localparam logic [127:0] FWD_IN_TXT  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
  localparam logic [127:0] FWD_OUT_TXT = 128'hd42711aee0bf98f1b8b45de51e415230;

  function automatic logic [127:0] bswap(input logic [127:0] v);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = v[8*(15-i) +: 8];
    return r;
  endfunction

  // Independent S-box model: GF(2^8) inverse followed by the affine transform.
  function automatic logic [7:0] gf_mul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    a = a_in; b = b_in; p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] sb_model(input logic [7:0] x);
    logic [7:0] inv, r;
    inv = 8'h01;
    for (int i = 0; i < 254; i++) inv = gf_mul(inv, x);
    r = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    return r;
  endfunction

  task automatic run_word(input logic [127:0] d, input logic inv, output logic [127:0] res, output int lat);
    int n;
    n = 0;
    @(negedge clk);
    while (!o_in_ready && n < 50) begin @(negedge clk); n++; end
    drv_data = d; drv_inv = inv; drv_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    drv_valid = 1'b0;
    lat = 0;
    while (!o_valid && lat < 40) begin @(posedge clk); lat++; @(negedge clk); end
    if (!o_valid) begin
      checks++; failures++;
      $display("FAIL run_word_timeout sel=%0d out_valid=%b required=1", sel, o_valid);
    end
    res = o_data;
    drv_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    drv_ready = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    checks++; if (o_in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", o_in_ready); end
    checks++; if (o_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", o_valid); end
    checks++; if (o_data !== 128'h0) begin failures++; $display("FAIL reset_out_data got=%h exp=0", o_data); end
    checks++; if (o_busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", o_busy); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_forward();
    logic [127:0] res; int lat;
    run_word(bswap(FWD_IN_TXT), 1'b0, res, lat);
    checks++; if (res !== bswap(FWD_OUT_TXT)) begin failures++; $display("FAIL fwd_data got=%h exp=%h", res, bswap(FWD_OUT_TXT)); end
    checks++; if (lat !== 4) begin failures++; $display("FAIL fwd_latency got=%0d exp=4", lat); end
    checks++; if (o_in_ready !== 1'b1 || o_busy !== 1'b0) begin failures++; $display("FAIL fwd_back_to_idle in_ready=%b busy=%b exp 1/0", o_in_ready, o_busy); end
  endtask

  task automatic test_inverse();
    logic [127:0] res; int lat;
    run_word(bswap(FWD_OUT_TXT), 1'b1, res, lat);
    checks++; if (res !== bswap(FWD_IN_TXT)) begin failures++; $display("FAIL inv_data got=%h exp=%h", res, bswap(FWD_IN_TXT)); end
    checks++; if (lat !== 4) begin failures++; $display("FAIL inv_latency got=%0d exp=4", lat); end
  endtask

  task automatic test_exhaustive();
    logic [127:0] d, e, res; int lat;
    for (int w = 0; w < 16; w++) begin
      for (int i = 0; i < 16; i++) begin
        d[8*i +: 8] = 8'(16*w + i);
        e[8*i +: 8] = sb_model(8'(16*w + i));
      end
      run_word(d, 1'b0, res, lat);
      checks++; if (res !== e) begin failures++; $display("FAIL exh_fwd word=%0d got=%h exp=%h", w, res, e); end
      run_word(e, 1'b1, res, lat);
      checks++; if (res !== d) begin failures++; $display("FAIL exh_inv word=%0d got=%h exp=%h", w, res, d); end
    end
  endtask

  task automatic test_backpressure();
    logic [127:0] exp_a, exp_b, res; int n;
    exp_a = bswap(FWD_OUT_TXT);
    exp_b = {8{8'h16, 8'h63}};
    @(negedge clk);
    drv_data = bswap(FWD_IN_TXT); drv_inv = 1'b0; drv_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    drv_data = {8{8'hff, 8'h00}};
    n = 0;
    while (!o_valid && n < 40) begin @(posedge clk); n++; @(negedge clk); end
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (o_valid !== 1'b1 || o_in_ready !== 1'b0 || o_busy !== 1'b1 || o_data !== exp_a) begin
        failures++;
        $display("FAIL bp_hold cycle=%0d valid=%b in_ready=%b busy=%b data=%h exp 1/0/1 %h", c, o_valid, o_in_ready, o_busy, o_data, exp_a);
      end
    end
    drv_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    drv_ready = 1'b0;
    checks++; if (o_valid !== 1'b0 || o_in_ready !== 1'b1) begin failures++; $display("FAIL bp_release valid=%b in_ready=%b exp 0/1", o_valid, o_in_ready); end
    @(posedge clk);
    @(negedge clk);
    drv_valid = 1'b0;
    checks++; if (o_in_ready !== 1'b0 || o_busy !== 1'b1) begin failures++; $display("FAIL bp_second_accept in_ready=%b busy=%b exp 0/1", o_in_ready, o_busy); end
    n = 0;
    while (!o_valid && n < 40) begin @(posedge clk); n++; @(negedge clk); end
    res = o_data;
    checks++; if (res !== exp_b) begin failures++; $display("FAIL bp_second_data got=%h exp=%h", res, exp_b); end
    checks++; if (n !== 4) begin failures++; $display("FAIL bp_second_latency got=%0d exp=4", n); end
    drv_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    drv_ready = 1'b0;
  endtask

  task automatic test_reset_mid_busy();
    logic [127:0] res; int lat;
    @(negedge clk);
    drv_data = bswap(FWD_IN_TXT); drv_inv = 1'b0; drv_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    drv_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    checks++; if (o_busy !== 1'b1 || o_valid !== 1'b0) begin failures++; $display("FAIL rst_pre_busy busy=%b valid=%b exp 1/0", o_busy, o_valid); end
    rst = 1'b1;
    #1;
    checks++;
    if (o_valid !== 1'b0 || o_data !== 128'h0 || o_in_ready !== 1'b1 || o_busy !== 1'b0) begin
      failures++;
      $display("FAIL rst_mid_busy valid=%b data=%h in_ready=%b busy=%b exp 0/0/1/0", o_valid, o_data, o_in_ready, o_busy);
    end
    @(negedge clk);
    rst = 1'b0;
    run_word(bswap(FWD_OUT_TXT), 1'b1, res, lat);
    checks++; if (res !== bswap(FWD_IN_TXT)) begin failures++; $display("FAIL rst_recover_data got=%h exp=%h", res, bswap(FWD_IN_TXT)); end
  endtask

  task automatic test_params();
    logic [127:0] res; int lat;
    sel = 1;
    run_word(bswap(FWD_IN_TXT), 1'b0, res, lat);
    checks++; if (res !== bswap(FWD_OUT_TXT)) begin failures++; $display("FAIL l16_data got=%h exp=%h", res, bswap(FWD_OUT_TXT)); end
    checks++; if (lat !== 1) begin failures++; $display("FAIL l16_latency got=%0d exp=1", lat); end
    sel = 2;
    run_word(bswap(FWD_IN_TXT), 1'b0, res, lat);
    checks++; if (res !== bswap(FWD_OUT_TXT)) begin failures++; $display("FAIL l1_data got=%h exp=%h", res, bswap(FWD_OUT_TXT)); end
    checks++; if (lat !== 16) begin failures++; $display("FAIL l1_latency got=%0d exp=16", lat); end
    sel = 3;
    run_word(bswap(FWD_IN_TXT), 1'b1, res, lat);
    checks++; if (res !== bswap(FWD_OUT_TXT)) begin failures++; $display("FAIL noinv_data got=%h exp=%h", res, bswap(FWD_OUT_TXT)); end
    checks++; if (lat !== 4) begin failures++; $display("FAIL noinv_latency got=%0d exp=4", lat); end
    sel = 0;
  endtask

  initial begin
    test_reset();
    test_forward();
    test_inverse();
    test_exhaustive();
    test_backpressure();
    test_reset_mid_busy();
    test_params();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
